// File: rtl/jk_counter_reg.sv
// Multi-mode register: per-bit JK flip-flops, modulo up/down counter, or parallel load.
// Tc flags a terminal count on the current edge; Wrap pulses for one cycle after a wrap.
module jk_counter_reg #(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic             Tc,
  output logic             Wrap
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  // One extra bit so a modulus of 2^WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             at_max, at_zero, out_of_range;

  assign at_max       = (q_q == MAX_VAL);
  assign at_zero      = (q_q == '0);
  assign out_of_range = ({1'b0, q_q} >= MOD_EXT);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (En) begin
      case (Mode)
        MODE_JK: q_d = (J & ~q_q) | (~K & q_q);
        MODE_UP: begin
          if (at_max) begin
            q_d    = '0;
            wrap_d = 1'b1;
          end else if (out_of_range) begin
            q_d = '0;
          end else begin
            q_d = q_q + ONE;
          end
        end
        MODE_DOWN: begin
          // Out-of-range recovery lands on MAX_VAL but is not a wrap.
          if (at_zero) begin
            q_d    = MAX_VAL;
            wrap_d = 1'b1;
          end else if (out_of_range) begin
            q_d = MAX_VAL;
          end else begin
            q_d = q_q - ONE;
          end
        end
        default: q_d = J;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign Qb   = ~q_q;
  assign Wrap = wrap_q;
  assign Tc   = En & (((Mode == MODE_UP) & at_max) | ((Mode == MODE_DOWN) & at_zero));

endmodule

// File: tb/tb_jk_counter_reg.sv
// Bench for jk_counter_reg (WIDTH=4, MODULUS=10): directed scenarios plus a
// randomized run, all checked against a behavioural model of the register.
module tb_jk_counter_reg;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic         Clk = 1'b0;
  logic         Clr = 1'b1;
  logic         En = 1'b0;
  logic [1:0]   Mode = 2'b00;
  logic [W-1:0] J = '0;
  logic [W-1:0] K = '0;
  logic [W-1:0] Q, Qb;
  logic         Tc, Wrap;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  int m_q    = 0;
  int m_wrap = 0;

  jk_counter_reg #(.WIDTH(W), .MODULUS(MOD)) dut (
    .Clk(Clk), .Clr(Clr), .En(En), .Mode(Mode), .J(J), .K(K),
    .Q(Q), .Qb(Qb), .Tc(Tc), .Wrap(Wrap)
  );

  always #5 Clk = ~Clk;

  function automatic void model_update();
    int nq;
    nq = m_q;
    m_wrap = 0;
    if (Clr == 1'b0) begin
      nq = 0;
    end else if (En) begin
      case (int'(Mode))
        0: begin
          for (int b = 0; b < W; b++) begin
            int qb, jb, kb;
            qb = (m_q >> b) & 1;
            jb = int'(J[b]);
            kb = int'(K[b]);
            if (jb == 1 && kb == 1) qb = 1 - qb;
            else if (jb == 1)       qb = 1;
            else if (kb == 1)       qb = 0;
            nq = (nq & ~(1 << b)) | (qb << b);
          end
        end
        1: begin
          if (m_q == MOD - 1) begin nq = 0; m_wrap = 1; end
          else if (m_q >= MOD) nq = 0;
          else nq = m_q + 1;
        end
        2: begin
          if (m_q == 0) begin nq = MOD - 1; m_wrap = 1; end
          else if (m_q >= MOD) nq = MOD - 1;
          else nq = m_q - 1;
        end
        default: nq = int'(J);
      endcase
    end
    m_q = nq;
  endfunction

  function automatic logic model_tc();
    return En && ((Mode == 2'b01 && m_q == MOD - 1) || (Mode == 2'b10 && m_q == 0));
  endfunction

  task automatic tick();
    model_update();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input int v);
    Clr = 1'b1; En = 1'b1; Mode = 2'b11; J = W'(v);
    tick();
  endtask

  task automatic test_reset();
    Clr = 1'b0; En = 1'b1; Mode = 2'b11; J = 4'hF; K = 4'h0;
    tick();
    total++; if (Q !== 4'h0) begin bad++; $display("FAIL reset_q got=%h exp=0", Q); end
    total++; if (Qb !== 4'hF) begin bad++; $display("FAIL reset_qb got=%h exp=f", Qb); end
    total++; if (Wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", Wrap); end
    total++; if (Tc !== 1'b0) begin bad++; $display("FAIL reset_tc_load got=%b exp=0", Tc); end
    Clr = 1'b1; Mode = 2'b10; #1;
    total++; if (Tc !== 1'b1) begin bad++; $display("FAIL reset_tc_down got=%b exp=1", Tc); end
  endtask

  task automatic test_jk();
    load(5);
    Mode = 2'b00; J = 4'b1100; K = 4'b1010; #1;
    total++; if (Tc !== 1'b0) begin bad++; $display("FAIL jk_tc got=%b exp=0", Tc); end
    tick();
    total++; if (Q !== 4'b1101) begin bad++; $display("FAIL jk_q got=%b exp=1101", Q); end
    total++; if (Q !== W'(m_q)) begin bad++; $display("FAIL jk_model got=%b exp=%b", Q, W'(m_q)); end
  endtask

  task automatic test_up();
    load(0);
    Mode = 2'b01;
    for (int i = 1; i <= 9; i++) begin
      tick();
      total++; if (Q !== W'(i)) begin bad++; $display("FAIL up_q step=%0d got=%0d exp=%0d", i, Q, i); end
    end
    total++; if (Tc !== 1'b1) begin bad++; $display("FAIL up_tc9 got=%b exp=1", Tc); end
    tick();
    total++; if (Q !== 4'd0 || Wrap !== 1'b1) begin bad++; $display("FAIL up_wrap q=%0d wrap=%b exp q=0 wrap=1", Q, Wrap); end
    tick();
    total++; if (Q !== 4'd1 || Wrap !== 1'b0) begin bad++; $display("FAIL up_after_wrap q=%0d wrap=%b exp q=1 wrap=0", Q, Wrap); end
    load(5);
    En = 1'b0; Mode = 2'b01;
    for (int i = 0; i < 3; i++) tick();
    total++; if (Q !== 4'd5) begin bad++; $display("FAIL hold_q got=%0d exp=5", Q); end
    total++; if (Tc !== 1'b0 || Wrap !== 1'b0) begin bad++; $display("FAIL hold_flags tc=%b wrap=%b exp 0 0", Tc, Wrap); end
  endtask

  task automatic test_down();
    load(0);
    Mode = 2'b10; #1;
    total++; if (Tc !== 1'b1) begin bad++; $display("FAIL down_tc0 got=%b exp=1", Tc); end
    tick();
    total++; if (Q !== 4'd9 || Wrap !== 1'b1) begin bad++; $display("FAIL down_wrap q=%0d wrap=%b exp q=9 wrap=1", Q, Wrap); end
    tick();
    total++; if (Q !== 4'd8 || Wrap !== 1'b0) begin bad++; $display("FAIL down_next q=%0d wrap=%b exp q=8 wrap=0", Q, Wrap); end
  endtask

  task automatic test_out_of_range();
    load(13);
    total++; if (Q !== 4'd13) begin bad++; $display("FAIL load_13 got=%0d exp=13", Q); end
    Mode = 2'b01; #1;
    total++; if (Tc !== 1'b0) begin bad++; $display("FAIL oor_tc got=%b exp=0", Tc); end
    tick();
    total++; if (Q !== 4'd0 || Wrap !== 1'b0) begin bad++; $display("FAIL oor_up q=%0d wrap=%b exp q=0 wrap=0", Q, Wrap); end
    load(13);
    Mode = 2'b10;
    tick();
    total++; if (Q !== 4'd9 || Wrap !== 1'b0) begin bad++; $display("FAIL oor_down q=%0d wrap=%b exp q=9 wrap=0", Q, Wrap); end
  endtask

  task automatic test_mid_reset();
    load(5);
    Mode = 2'b01;
    tick(); tick();
    total++; if (Q !== 4'd7) begin bad++; $display("FAIL mid_pre got=%0d exp=7", Q); end
    Clr = 1'b0;
    tick();
    total++; if (Q !== 4'd0 || Wrap !== 1'b0) begin bad++; $display("FAIL mid_reset q=%0d wrap=%b exp q=0 wrap=0", Q, Wrap); end
    Clr = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      total++; if (Q !== W'(i)) begin bad++; $display("FAIL mid_resume got=%0d exp=%0d", Q, i); end
    end
    // Reset on the edge that would have wrapped must suppress the pulse.
    load(9);
    Mode = 2'b01; Clr = 1'b0;
    tick();
    total++; if (Q !== 4'd0 || Wrap !== 1'b0) begin bad++; $display("FAIL reset_at_wrap q=%0d wrap=%b exp q=0 wrap=0", Q, Wrap); end
    Clr = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      Clr  = ($urandom_range(0, 19) != 0);
      En   = ($urandom_range(0, 4) != 0);
      Mode = 2'($urandom_range(0, 3));
      J    = W'($urandom);
      K    = W'($urandom);
      #1;
      total++; if (Tc !== model_tc()) begin bad++; $display("FAIL rand_tc n=%0d got=%b exp=%b q=%0d mode=%0d en=%b", n, Tc, model_tc(), Q, Mode, En); end
      tick();
      total++; if (Q !== W'(m_q) || Qb !== ~W'(m_q)) begin bad++; $display("FAIL rand_q n=%0d q=%h qb=%h exp q=%h", n, Q, Qb, W'(m_q)); end
      total++; if (Wrap !== m_wrap[0]) begin bad++; $display("FAIL rand_wrap n=%0d got=%b exp=%0d", n, Wrap, m_wrap); end
    end
  endtask

  initial begin
    test_reset();
    test_jk();
    test_up();
    test_down();
    test_out_of_range();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_counter_reg.md
JK_COUNTER_REG -- requirements
Module: jk_counter_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the register width in bits (legal range 1..32).
REQ-002 The block SHALL have parameter MODULUS, default 16, giving the count modulus (legal range 2..2^WIDTH).
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-004 The block SHALL have port Clr, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port En, input, 1 bit: update enable; when low, state holds.
REQ-006 The block SHALL have port Mode, input, 2 bits: operation select (00 JK, 01 count up, 10 count down, 11 load).
REQ-007 The block SHALL have port J, input, WIDTH bits: per-bit J inputs in JK mode, and load data in load mode.
REQ-008 The block SHALL have port K, input, WIDTH bits: per-bit K inputs in JK mode; ignored in all other modes.
REQ-009 The block SHALL have port Q, output, WIDTH bits: registered state.
REQ-010 The block SHALL have port Qb, output, WIDTH bits: bitwise complement of Q, always.
REQ-011 The block SHALL have port Tc, output, 1 bit: combinational terminal-count flag.
REQ-012 The block SHALL have port Wrap, output, 1 bit: registered one-cycle pulse marking a wrap-around.

Function
REQ-013 All state (Q, Wrap) SHALL update only on the rising edge of Clk.
REQ-014 When Clr=1 and En=0, Q SHALL hold and Wrap SHALL be 0 on the next cycle.
REQ-015 For Mode=00 (JK), each bit SHALL follow Q[i]+ = (J[i] & ~Q[i]) | (~K[i] & Q[i]): 00 hold, 01 clear, 10 set, 11 toggle.
REQ-016 For Mode=01 (up), if Q < MODULUS-1 then Q+ = Q+1; if Q = MODULUS-1 or Q >= MODULUS, then Q+ = 0.
REQ-017 For Mode=10 (down), if 0 < Q < MODULUS then Q+ = Q-1; if Q = 0 or Q >= MODULUS, then Q+ = MODULUS-1.
REQ-018 For Mode=11 (load), Q+ SHALL be J, with no modulus check; K is ignored.
REQ-019 Arithmetic SHALL be unsigned at WIDTH bits; no carry or borrow SHALL be visible outside Q.
REQ-020 Tc SHALL be En & ((Mode=01 & Q=MODULUS-1) | (Mode=10 & Q=0)), and 0 in modes 00 and 11.
REQ-021 Wrap SHALL be 1 in the cycle after an enabled edge where Mode=01 with Q=MODULUS-1, or Mode=10 with Q=0; otherwise Wrap SHALL be 0.
REQ-022 Out-of-range recovery (Q >= MODULUS under REQ-016/REQ-017) SHALL NOT assert Wrap.
REQ-023 A Mode change SHALL take effect on the next rising edge, with no pipeline delay; latency from input to Q is 1 cycle.
REQ-024 Qb SHALL be derived combinationally from Q and SHALL never equal Q in any bit.

Reset
REQ-025 If Clr=0 at a rising edge, Q SHALL be 0 and Wrap SHALL be 0 after that edge, regardless of En, Mode, J or K.
REQ-026 Reset SHALL take priority over every mode, including mid-count and mid-load.
REQ-027 After reset, Qb SHALL be all ones.
REQ-028 After reset, Tc SHALL reflect REQ-020 (1 if En=1 and Mode=10, else 0).
REQ-029 Clr SHALL have no effect between clock edges.

Verification (WIDTH=4, MODULUS=10)
REQ-030 Reset: Clr=0 for 1 edge with Mode=11, J=4'hF, En=1 -> Q=0, Qb=4'hF, Wrap=0; then Clr=1.
REQ-031 JK mode: Q=4'b0101, J=4'b1100, K=4'b1010, En=1 -> Q=4'b1101 after one edge.
- Bit 3 toggles, bit 2 sets, bit 1 clears, bit 0 holds.
REQ-032 Up count from 0: 9 edges -> Q=9 and Tc=1; 10th edge -> Q=0 and Wrap=1 for exactly one cycle.
- En=0 for 3 edges at Q=5 -> Q stays 5, Tc=0.
REQ-033 Down count from Q=0: Tc=1; next edge -> Q=9 and Wrap=1; next edge -> Q=8 and Wrap=0.
REQ-034 Out of range: load J=4'd13 then Mode=01 -> Q=0 and Wrap=0.
- Load J=4'd13 then Mode=10 -> Q=9 and Wrap=0.
REQ-035 Mid-operation reset: up-counting at Q=7, Clr=0 on one edge -> Q=0, Wrap=0.
- Counting resumes 0,1,2 once Clr=1.
